// File: rtl/main_func_udiv_17ns_3ns_15_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock, with valid/ready
// handshakes on both sides. Recovers the 15-bit operand of the 3x15->17 multiplier.
module main_func_udiv_17ns_3ns_15_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 17,
  parameter int din1_WIDTH = 3,
  parameter int dout_WIDTH = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_zero,
  output logic                  ovf
);

  localparam int N  = din0_WIDTH;
  localparam int D  = din1_WIDTH;
  localparam int Q  = dout_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CntInit = CW'(N);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q;
  logic [N-1:0]  dividend_q;
  logic [D-1:0]  divisor_q;
  logic [D-1:0]  rpart_q;
  logic [N-1:0]  q_q;
  logic [CW-1:0] cnt_q;

  // Instance tag carries no function.
  logic unused_id;
  assign unused_id = (ID == 0);

  // One restoring step: the partial remainder stays below the divisor, so D+1 bits
  // suffice for the trial subtraction.
  logic [D:0]   trial;
  logic [D:0]   trial_sub;
  logic         qbit;
  logic [D-1:0] rpart_next;
  logic [N-1:0] q_next;
  logic         ovf_next;

  always_comb begin
    trial      = {rpart_q, dividend_q[N-1]};
    trial_sub  = trial - {1'b0, divisor_q};
    qbit       = (trial >= {1'b0, divisor_q});
    rpart_next = qbit ? trial_sub[D-1:0] : trial[D-1:0];
    q_next     = {q_q[N-2:0], qbit};
    ovf_next   = ((q_next >> Q) != '0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      dividend_q <= '0;
      divisor_q  <= '0;
      rpart_q    <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      quot       <= '0;
      rem        <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            dividend_q <= din0;
            divisor_q  <= din1;
            rpart_q    <= '0;
            q_q        <= '0;
            cnt_q      <= CntInit;
            in_ready   <= 1'b0;
            if (din1 == '0) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              quot      <= '1;
              rem       <= din0[D-1:0];
              div_zero  <= 1'b1;
              ovf       <= 1'b0;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          dividend_q <= {dividend_q[N-2:0], 1'b0};
          rpart_q    <= rpart_next;
          q_q        <= q_next;
          cnt_q      <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            quot      <= q_next[Q-1:0];
            rem       <= rpart_next;
            div_zero  <= 1'b0;
            ovf       <= ovf_next;
          end
        end
        StDone: begin
          // No accept on the handoff edge: in_ready only rises afterwards.
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q  <= StIdle;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/main_func_udiv_17ns_3ns_15_seq.md
Name: main_func_udiv_17ns_3ns_15_seq

Overview:
Iterative unsigned restoring divider. It is the inverse of the 3ns x 15ns -> 17-bit multiplier in the main_func datapath: it recovers the 15-bit operand from a 17-bit product and the 3-bit factor. It produces one quotient bit per clock and uses a valid/ready handshake on both its input and output sides. It instantiates beside the main_func multipliers and is driven by the HLS-generated FSM.

Parameters:
ID, 1, instance tag; no functional effect
din0_WIDTH, 17, dividend width (N)
din1_WIDTH, 3, divisor width (D)
dout_WIDTH, 15, quotient output width (Q); Q <= N

Ports:
ap_clk  input  1  clock; all state changes on the rising edge
ap_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair present on din0/din1
in_ready  output  1  divider idle and able to accept an operand pair
din0  input  N  unsigned dividend
din1  input  D  unsigned divisor
out_valid  output  1  result registers hold a valid result
out_ready  input  1  consumer accepts the result
quot  output  Q  quotient, low Q bits
rem  output  D  remainder
div_zero  output  1  the divisor of this result was 0
ovf  output  1  the full N-bit quotient did not fit in Q bits

Behaviour:
- Clock and reset: one clock, ap_clk. Reset ap_rst_n is asynchronous and active-low.
- Reset: state=IDLE; in_ready=1; out_valid=0; quot=0; rem=0; div_zero=0; ovf=0; iteration counter=0.
- A reset asserted mid-operation aborts the division immediately. No result is produced afterwards.
- State machine: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - An accept edge is one where in_valid=1 and in_ready=1. On it, latch the dividend into a shift register, latch the divisor, clear the partial remainder and the quotient, and set the counter to N.
  - If din1==0 at the accept edge, go directly to DONE with quot=all ones, rem=din0[D-1:0], div_zero=1, ovf=0.
  - Otherwise go to CALC.
- CALC (in_ready=0), one restoring step per edge:
  - t = {rem_partial, dividend MSB}, D+1 bits.
  - If t >= divisor: rem_partial = t - divisor and the new quotient bit = 1.
  - Else: rem_partial = t[D-1:0] and the new quotient bit = 0.
  - Shift the dividend left by 1, shift the quotient bit into the quotient LSB, and decrement the counter.
  - On the step where the counter goes 1 -> 0, go to DONE. Load quot = q[Q-1:0] and rem = rem_partial.
  - ovf = 1 if any of q[N-1:Q] is nonzero.
- DONE:
  - out_valid=1. quot, rem, div_zero and ovf stay stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, set out_valid=0 and go to IDLE.
  - in_ready=0 in DONE, so no new operand pair is accepted in the same edge as the output handoff. Back-to-back throughput is N+2 cycles per operation.
- Latency: out_valid is first high in the cycle after accept edge + N, i.e. 17 edges after acceptance. For a zero divisor it is high in the cycle right after the accept edge.
- Outputs stay registered after the handoff. quot, rem, div_zero and ovf hold their last values after out_valid falls, until the next result loads.
- Width rules:
  - All arithmetic is unsigned.
  - The partial remainder is always < divisor, so D bits are enough.
  - The compare/subtract is D+1 bits wide.
- The invariant {q, rem} satisfies q*divisor + rem == dividend, using the full N-bit quotient, for every nonzero divisor.
- in_valid, din0 and din1 are ignored outside IDLE. out_ready is ignored outside DONE.

Test Plan:
1. Reset then exact division: din0=17'd98301 (7*14043), din1=3'd7 -> out_valid 17 cycles after accept; quot=14043, rem=0, ovf=0, div_zero=0.
2. Remainder and corner: din0=17'h1FFFF, din1=3'd5 -> quot=15'd26214, rem=1, ovf=0. Also din0=17'h1FFFF, din1=3'd1 -> quot=15'h7FFF, ovf=1, rem=0.
3. Divide by zero: din0=17'd12345, din1=0 -> out_valid the cycle after accept; quot=15'h7FFF, rem=3'd1 (12345 mod 8), div_zero=1.
4. Output backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. A new in_valid during the stall is not accepted. Release out_ready -> in_ready=1 on the next cycle.
5. Mid-operation reset: assert ap_rst_n=0 asynchronously 8 cycles into CALC -> all outputs take their reset values with no clock edge. After release, a fresh operand pair of 100/3 gives quot=33, rem=1.
6. Random regression: 10k random pairs with din1 != 0, random out_ready stalls -> q*din1 + rem == din0 for the full q, ovf matches (din0/din1 >= 2^15), and no result is lost or duplicated.
